// File: rtl/cancid_stream_ctx.sv
// Per-stream context store for one regex matcher: saves/restores matcher state
// across interleaved packets and keeps saturating per-stream and total match counts.
module cancid_stream_ctx #(
  parameter int NUM_STREAMS = 64,
  parameter int SID_W       = 6,
  parameter int STATE_W     = 11,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sop,
  input  logic [SID_W-1:0]   pkt_stream,
  input  logic               enable,
  input  logic               new_stream,
  input  logic               eop,
  input  logic               clr_all,
  output logic [STATE_W-1:0] m_state_in,
  output logic               m_state_in_vld,
  input  logic [STATE_W-1:0] m_state_out,
  input  logic               m_accept,
  output logic               fired,
  output logic               busy,
  input  logic [SID_W-1:0]   rd_stream,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COUNT_W-1:0] total_count
);

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD, ACTIVE} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SID_W-1:0]   IDX_LAST = SID_W'(NUM_STREAMS - 1);

  state_t                 st_q;
  logic [SID_W-1:0]       idx_q;
  logic [SID_W-1:0]       sid_q;
  logic                   en_q;
  logic [COUNT_W-1:0]     cnt_q;
  logic [NUM_STREAMS-1:0] vld_q;

  logic [STATE_W-1:0] state_ram [NUM_STREAMS];
  logic [COUNT_W-1:0] count_ram [NUM_STREAMS];

  logic               hit;
  logic               commit;
  logic               take_sop;
  logic               byp;
  logic               ld_vld;
  logic [STATE_W-1:0] ld_state;
  logic [COUNT_W-1:0] ld_cnt;
  logic [COUNT_W-1:0] new_cnt;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v, input logic f);
    return (f && (v != CNT_MAX)) ? v + COUNT_W'(1) : v;
  endfunction

  assign busy     = (st_q == CLEAR);
  assign hit      = fired | m_accept;
  assign new_cnt  = sat_inc(cnt_q, hit);
  assign commit   = (st_q == ACTIVE) && eop && en_q && !clr_all;
  assign take_sop = sop && !clr_all && ((st_q == IDLE) || (st_q == ACTIVE));

  // A commit and a load of the same stream in one cycle forward the fresh values.
  assign byp      = commit && (pkt_stream == sid_q);
  assign ld_vld   = byp || vld_q[pkt_stream];
  assign ld_state = byp ? m_state_out : state_ram[pkt_stream];
  assign ld_cnt   = byp ? new_cnt : count_ram[pkt_stream];

  always_ff @(posedge clk) begin
    if (st_q == CLEAR) begin
      count_ram[idx_q] <= '0;
    end else if (commit) begin
      state_ram[sid_q] <= m_state_out;
      count_ram[sid_q] <= new_cnt;
    end
    rd_count <= count_ram[rd_stream];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q           <= CLEAR;
      idx_q          <= '0;
      vld_q          <= '0;
      sid_q          <= '0;
      en_q           <= 1'b0;
      cnt_q          <= '0;
      fired          <= 1'b0;
      m_state_in_vld <= 1'b0;
      m_state_in     <= '0;
      total_count    <= '0;
    end else begin
      m_state_in_vld <= 1'b0;
      if (clr_all) begin
        st_q        <= CLEAR;
        idx_q       <= '0;
        total_count <= '0;
      end else begin
        case (st_q)
          CLEAR: begin
            vld_q[idx_q] <= 1'b0;
            if (idx_q == IDX_LAST) st_q <= IDLE;
            else                   idx_q <= idx_q + 1'b1;
          end
          LOAD: st_q <= ACTIVE;
          ACTIVE: begin
            fired <= hit;
            if (eop) begin
              st_q <= IDLE;
              if (en_q) begin
                vld_q[sid_q] <= 1'b1;
                total_count  <= sat_inc(total_count, hit);
              end else begin
                fired <= 1'b0;
              end
            end
          end
          default: ;
        endcase
        // Also covers abort (sop without eop) and back-to-back eop+sop.
        if (take_sop) begin
          st_q           <= LOAD;
          sid_q          <= pkt_stream;
          en_q           <= enable;
          cnt_q          <= ld_cnt;
          fired          <= 1'b0;
          m_state_in_vld <= 1'b1;
          m_state_in     <= (new_stream || !ld_vld) ? '0 : ld_state;
        end
      end
    end
  end

endmodule

// File: tb/tb_cancid_stream_ctx.sv
// Bench for cancid_stream_ctx: directed and random packets checked against a
// per-stream array model of saved state, validity and saturating counts.
module tb_cancid_stream_ctx;

  localparam int NS   = 64;
  localparam int SW   = 6;
  localparam int STW  = 11;
  localparam int CW   = 8;  // narrow counters so saturation is reachable quickly
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sop = 1'b0;
  logic [SW-1:0]  pkt_stream = '0;
  logic           enable = 1'b0;
  logic           new_stream = 1'b0;
  logic           eop = 1'b0;
  logic           clr_all = 1'b0;
  logic [STW-1:0] m_state_in;
  logic           m_state_in_vld;
  logic [STW-1:0] m_state_out = '0;
  logic           m_accept = 1'b0;
  logic           fired;
  logic           busy;
  logic [SW-1:0]  rd_stream = '0;
  logic [CW-1:0]  rd_count;
  logic [CW-1:0]  total_count;

  cancid_stream_ctx #(.NUM_STREAMS(NS), .SID_W(SW), .STATE_W(STW), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sop(sop), .pkt_stream(pkt_stream), .enable(enable),
    .new_stream(new_stream), .eop(eop), .clr_all(clr_all), .m_state_in(m_state_in),
    .m_state_in_vld(m_state_in_vld), .m_state_out(m_state_out), .m_accept(m_accept),
    .fired(fired), .busy(busy), .rd_stream(rd_stream), .rd_count(rd_count),
    .total_count(total_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [STW-1:0] m_state [NS];
  bit             m_vld   [NS];
  int             m_cnt   [NS];
  int             m_total;
  int             cur_sid;
  bit             cur_en;
  logic [STW-1:0] exp_load;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat1(input int v, input bit f);
    return (f && v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_vld[i] = 1'b0;
      m_cnt[i] = 0;
    end
    m_total = 0;
  endtask

  task automatic model_sop(input int sid, input bit en, input bit nw);
    exp_load = (nw || !m_vld[sid]) ? '0 : m_state[sid];
    cur_sid  = sid;
    cur_en   = en;
  endtask

  // Called in the LOAD cycle; returns once the packet is ACTIVE.
  task automatic check_load();
    chk("load_vld", 32'(m_state_in_vld), 32'd1);
    chk("load_state", 32'(m_state_in), 32'(exp_load));
    @(negedge clk);
  endtask

  task automatic drive_sop(input int sid, input bit en, input bit nw);
    sop = 1'b1; pkt_stream = SW'(sid); enable = en; new_stream = nw;
    model_sop(sid, en, nw);
    @(negedge clk);
    sop = 1'b0;
    check_load();
  endtask

  task automatic body(input int len, input int acc_pct, input bit last_acc,
                      input logic [STW-1:0] fin, input bit chain,
                      input int csid, input bit cen, input bit cnw);
    bit any = 1'b0;
    for (int i = 0; i < len; i++) begin
      bit last = (i == len - 1);
      m_accept    = last ? last_acc : ($urandom_range(0, 99) < acc_pct);
      m_state_out = last ? fin : STW'($urandom);
      eop         = last;
      if (last && chain) begin
        sop = 1'b1; pkt_stream = SW'(csid); enable = cen; new_stream = cnw;
      end
      any = any | m_accept;
      @(negedge clk);
      if (!last) chk("fired_mid", 32'(fired), 32'(any));
    end
    eop = 1'b0; m_accept = 1'b0; sop = 1'b0;
    if (cur_en) begin
      m_state[cur_sid] = fin;
      m_vld[cur_sid]   = 1'b1;
      m_cnt[cur_sid]   = sat1(m_cnt[cur_sid], any);
      m_total          = sat1(m_total, any);
    end
    chk("total", 32'(total_count), 32'(m_total));
    if (chain) begin
      model_sop(csid, cen, cnw);
      check_load();
    end else begin
      chk("fired_end", 32'(fired), cur_en ? 32'(any) : 32'd0);
    end
  endtask

  task automatic rd_chk(input int sid);
    rd_stream = SW'(sid);
    @(negedge clk);
    chk("rd_count", 32'(rd_count), 32'(m_cnt[sid]));
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(NS));
  endtask

  initial begin
    bit in_load;
    model_clear();
    for (int i = 0; i < NS; i++) m_state[i] = '0;

    // Reset values and the power-up sweep.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ld_vld", 32'(m_state_in_vld), 32'd0);
    chk("rst_ld_state", 32'(m_state_in), 32'd0);
    chk("rst_fired", 32'(fired), 32'd0);
    chk("rst_total", 32'(total_count), 32'd0);
    rst = 1'b0;
    wait_clear("rst_busy_len");
    for (int s = 0; s < NS; s++) rd_chk(s);

    // Fresh stream, then resume from its saved state.
    drive_sop(5, 1'b1, 1'b1);
    body(3, 100, 1'b0, 11'h3C1, 1'b0, 0, 1'b0, 1'b0);
    rd_chk(5);
    drive_sop(5, 1'b1, 1'b0);
    body(2, 0, 1'b0, 11'h011, 1'b0, 0, 1'b0, 1'b0);

    // Interleaved streams and an unseen stream.
    drive_sop(3, 1'b1, 1'b1);
    body(3, 20, 1'b0, 11'h1A5, 1'b0, 0, 1'b0, 1'b0);
    drive_sop(9, 1'b1, 1'b1);
    body(2, 20, 1'b0, 11'h02C, 1'b0, 0, 1'b0, 1'b0);
    drive_sop(3, 1'b1, 1'b0);
    body(2, 20, 1'b0, 11'h600, 1'b0, 0, 1'b0, 1'b0);
    drive_sop(9, 1'b1, 1'b0);
    body(2, 20, 1'b0, 11'h0C3, 1'b0, 0, 1'b0, 1'b0);
    drive_sop(12, 1'b1, 1'b0);
    body(2, 0, 1'b0, 11'h4A4, 1'b0, 0, 1'b0, 1'b0);

    // Disabled packet leaves stream 7 untouched; eop-cycle accept counts.
    drive_sop(7, 1'b1, 1'b1);
    body(2, 0, 1'b0, 11'h123, 1'b0, 0, 1'b0, 1'b0);
    drive_sop(7, 1'b0, 1'b0);
    body(3, 100, 1'b0, 11'h7FF, 1'b0, 0, 1'b0, 1'b0);
    rd_chk(7);
    drive_sop(7, 1'b1, 1'b0);
    body(3, 0, 1'b1, 11'h055, 1'b0, 0, 1'b0, 1'b0);
    rd_chk(7);

    // Abort: sop without eop discards the open packet.
    drive_sop(6, 1'b1, 1'b1);
    body(2, 0, 1'b0, 11'h0F0, 1'b0, 0, 1'b0, 1'b0);
    drive_sop(6, 1'b1, 1'b0);
    m_accept = 1'b1; m_state_out = 11'h3FF;
    @(negedge clk);
    m_accept = 1'b0;
    sop = 1'b1; pkt_stream = SW'(6); enable = 1'b1; new_stream = 1'b0;
    model_sop(6, 1'b1, 1'b0);
    @(negedge clk);
    sop = 1'b0;
    check_load();
    body(2, 0, 1'b0, 11'h0F1, 1'b0, 0, 1'b0, 1'b0);
    rd_chk(6);

    // Saturation through back-to-back packets on stream 1.
    drive_sop(1, 1'b1, 1'b1);
    for (int k = 0; k <= CMAX + 1; k++)
      body(1, 0, 1'b1, STW'($urandom), (k <= CMAX), 1, 1'b1, 1'b0);
    rd_chk(1);

    // Three commits on stream 4, then clr_all mid-packet.
    for (int k = 0; k < 3; k++) begin
      drive_sop(4, 1'b1, 1'b0);
      body(2, 0, 1'b1, STW'($urandom), 1'b0, 0, 1'b0, 1'b0);
    end
    rd_chk(4);
    drive_sop(4, 1'b1, 1'b0);
    m_accept = 1'b1;
    @(negedge clk);
    m_accept = 1'b0; clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    model_clear();
    wait_clear("clr_busy_len");
    rd_chk(4);
    chk("clr_total", 32'(total_count), 32'd0);
    drive_sop(4, 1'b1, 1'b0);
    body(2, 0, 1'b0, 11'h111, 1'b0, 0, 1'b0, 1'b0);

    // Back-to-back eop+sop on the same stream uses the forwarded state.
    drive_sop(2, 1'b1, 1'b1);
    body(3, 30, 1'b0, 11'h2AB, 1'b1, 2, 1'b1, 1'b0);
    body(2, 30, 1'b1, 11'h0AA, 1'b0, 0, 1'b0, 1'b0);

    // Random interleaving with occasional chained packets.
    in_load = 1'b0;
    for (int p = 0; p < 40; p++) begin
      bit chain = ($urandom_range(0, 3) == 0);
      if (!in_load)
        drive_sop($urandom_range(0, 15), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
      body($urandom_range(1, 5), 30, 1'($urandom_range(0, 1)), STW'($urandom), chain,
           $urandom_range(0, 15), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
      in_load = chain;
    end
    if (in_load) body(2, 30, 1'b0, STW'($urandom), 1'b0, 0, 1'b0, 1'b0);
    for (int s = 0; s < 16; s++) rd_chk(s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
